// File: rtl/xillybus_axi_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// xillybus_axi_pkg: shared AXI3 encodings and responder state type.
// Rev 1.0
//------------------------------------------------------------------
package xillybus_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_4B) || (burst != BURST_INCR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xillybus_axi3_mem_responder_if.sv
`default_nettype none
//------------------------------------------------------------------
// xillybus_axi3_mem_responder_if: AXI3 32-bit bus between DMA master and responder.
// Rev 1.0
//------------------------------------------------------------------
interface xillybus_axi3_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [3:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic [2:0]        s_axi_arprot;
  logic [3:0]        s_axi_arcache;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [3:0]        s_axi_awlen;
  logic [2:0]        s_axi_awsize;
  logic [1:0]        s_axi_awburst;
  logic [2:0]        s_axi_awprot;
  logic [3:0]        s_axi_awcache;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [1:0]        s_axi_bresp;

  modport slave (
    input  s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arprot, s_axi_arcache, s_axi_rready,
           s_axi_awvalid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awprot, s_axi_awcache, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
           s_axi_wlast, s_axi_bready,
    output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp
  );

  modport master (
    output s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arprot, s_axi_arcache, s_axi_rready,
           s_axi_awvalid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awprot, s_axi_awcache, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
           s_axi_wlast, s_axi_bready,
    input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp
  );
endinterface
`default_nettype wire

// File: rtl/xillybus_bram_sp.sv
`default_nettype none
//------------------------------------------------------------------
// xillybus_bram_sp: single-port 32-bit block RAM, byte write enables, registered read.
// Rev 1.0
//------------------------------------------------------------------
module xillybus_bram_sp #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  // No reset: contents and read register must map onto block RAM primitives.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/xillybus_axi3_mem_responder.sv
`default_nettype none
//------------------------------------------------------------------
// xillybus_axi3_mem_responder: AXI3 slave serving one burst at a time from block RAM.
// Rev 1.0
//------------------------------------------------------------------
module xillybus_axi3_mem_responder
  import xillybus_axi_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int ADDR_W = 32
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  xillybus_axi3_mem_responder_if.slave  s_axi
);
  state_e            state_q, state_d;
  logic              last_grant_q;
  logic [MEM_AW-1:0] addr_q;
  logic [3:0]        len_q, cnt_q;
  logic              err_q;
  logic              wready_q, bvalid_q, rvalid_q, rlast_q;
  logic [1:0]        bresp_q, rresp_q;
  logic              aw_grant, ar_grant, w_hs, beat_last, wlast_bad;
  logic [3:0]        mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              unused_ok;

  assign aw_grant  = (state_q == ST_IDLE) && s_axi.s_axi_awvalid &&
                     (!s_axi.s_axi_arvalid || (last_grant_q == GRANT_READ));
  assign ar_grant  = (state_q == ST_IDLE) && s_axi.s_axi_arvalid && !aw_grant;
  assign w_hs      = (state_q == ST_WDATA) && s_axi.s_axi_wvalid && wready_q;
  assign beat_last = (cnt_q == len_q);
  assign wlast_bad = (s_axi.s_axi_wlast != beat_last);
  assign mem_we    = (w_hs && !err_q) ? s_axi.s_axi_wstrb : 4'b0000;
  assign mem_re    = (state_q == ST_RADDR);

  assign s_axi.s_axi_awready = aw_grant;
  assign s_axi.s_axi_arready = ar_grant;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign s_axi.s_axi_rlast   = rlast_q;
  // RAM output register holds between RADDR visits, so rdata stays put while stalled.
  assign s_axi.s_axi_rdata   = (rvalid_q && !err_q) ? mem_rdata : 32'h0;

  assign unused_ok = ^{s_axi.s_axi_araddr[ADDR_W-1:MEM_AW+2], s_axi.s_axi_araddr[1:0],
                       s_axi.s_axi_awaddr[ADDR_W-1:MEM_AW+2], s_axi.s_axi_awaddr[1:0],
                       s_axi.s_axi_arprot, s_axi.s_axi_arcache,
                       s_axi.s_axi_awprot, s_axi.s_axi_awcache};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (aw_grant) state_d = ST_WDATA;
                else if (ar_grant) state_d = ST_RADDR;
      ST_WDATA: if (w_hs && beat_last) state_d = ST_WRESP;
      ST_WRESP: if (s_axi.s_axi_bready) state_d = ST_IDLE;
      ST_RADDR: state_d = ST_RDATA;
      ST_RDATA: if (s_axi.s_axi_rready) state_d = beat_last ? ST_IDLE : ST_RADDR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (aw_grant) begin
            last_grant_q <= GRANT_WRITE;
            addr_q       <= s_axi.s_axi_awaddr[MEM_AW+1:2];
            len_q        <= s_axi.s_axi_awlen;
            cnt_q        <= '0;
            err_q        <= req_err(s_axi.s_axi_awsize, s_axi.s_axi_awburst);
            wready_q     <= 1'b1;
          end else if (ar_grant) begin
            last_grant_q <= GRANT_READ;
            addr_q       <= s_axi.s_axi_araddr[MEM_AW+1:2];
            len_q        <= s_axi.s_axi_arlen;
            cnt_q        <= '0;
            err_q        <= req_err(s_axi.s_axi_arsize, s_axi.s_axi_arburst);
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            if (wlast_bad) err_q <= 1'b1;
            if (beat_last) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              cnt_q  <= cnt_q + 4'd1;
              addr_q <= addr_q + MEM_AW'(1);
            end
          end
        end
        ST_WRESP: if (s_axi.s_axi_bready) bvalid_q <= 1'b0;
        ST_RADDR: begin
          rvalid_q <= 1'b1;
          rlast_q  <= beat_last;
          rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
        end
        ST_RDATA: begin
          if (s_axi.s_axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (!beat_last) begin
              cnt_q  <= cnt_q + 4'd1;
              addr_q <= addr_q + MEM_AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  xillybus_bram_sp #(.AW(MEM_AW)) u_bram (
    .clk_i   (s_axi_aclk),
    .addr_i  (addr_q),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .wdata_i (s_axi.s_axi_wdata),
    .rdata_o (mem_rdata)
  );
endmodule
`default_nettype wire
